reg_bank_arbiter: RTL and testbench

// - Owns the 8-bit configuration register bank and shares access between two requesters:
//   - port A: the I2C slave (host writes/reads);
//   - port B: the on-chip IO engine (status write-back, config reads).
// - Drives registers_packed to the IO datapath.
// - Arbitrates round-robin with optional A-priority and burst locking, so multi-byte I2C

---
 rtl/reg_bank_arbiter_pkg.sv | 21 ++
 rtl/reg_bank_arbiter_if.sv | 16 +
 rtl/reg_bank_arbiter_rr_arb2.sv | 18 +
 rtl/reg_bank_arbiter.sv | 115 +++++++++++
 tb/tb_reg_bank_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and sizing for the configuration register bank and its two-port arbiter.
package reg_bank_pkg;

  localparam int REGCOUNT = 16;
  localparam int ADDR_W   = $clog2(REGCOUNT);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} owner_t;

  // Encoding of the round-robin history bit.
  localparam logic WINNER_A = 1'b0;
  localparam logic WINNER_B = 1'b1;

  typedef struct packed {
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } rb_req_t;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// One requester port of the register bank: request/write bus in, grant and read data out.
interface reg_bank_arbiter_if;
  import reg_bank_pkg::*;

  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic              gnt;
  logic              rvalid;
  logic [7:0]        rdata;

  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/reg_bank_arbiter_rr_arb2.sv
// Two-way pick: a lone requester wins; on a tie A wins under priority, else the port that lost last.
module rr_arb2
  import reg_bank_pkg::*;
(
  input  logic [1:0] req,          // bit 0 = port A, bit 1 = port B
  input  logic       last_winner,
  input  logic       prio_a,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (prio_a || last_winner == WINNER_B) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Configuration register bank shared by the I2C slave (port A) and the IO engine (port B),
// with round-robin/priority arbitration and lockable bursts.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int          REGCOUNT   = reg_bank_pkg::REGCOUNT,
  parameter bit          A_PRIORITY = 1'b0,
  parameter logic [15:0] WP_MASK    = 16'h0000
) (
  input  logic                    clock,
  input  logic                    reset,
  reg_bank_arbiter_if.slave       port_a,
  reg_bank_arbiter_if.slave       port_b,
  output logic                    b_wp_err,
  output logic [7:0]              conflict_cnt,
  output logic [8*REGCOUNT-1:0]   registers_packed
);

  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(REGCOUNT);

  owner_t     owner, owner_nxt;
  logic       last_winner;
  logic [1:0] pick;
  logic       a_gnt, b_gnt;
  logic [7:0] regs [REGCOUNT];

  rb_req_t a_in, b_in, sel;
  logic    sel_valid, sel_in_range, sel_protected;

  assign a_in = '{req: port_a.req, we: port_a.we, lock: port_a.lock,
                  addr: port_a.addr, wdata: port_a.wdata};
  assign b_in = '{req: port_b.req, we: port_b.we, lock: port_b.lock,
                  addr: port_b.addr, wdata: port_b.wdata};

  rr_arb2 u_arb (
    .req         ({b_in.req, a_in.req}),
    .last_winner (last_winner),
    .prio_a      (A_PRIORITY),
    .grant       (pick)
  );

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    owner_nxt = owner;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    case (owner)
      IDLE:    begin a_gnt = pick[0]; b_gnt = pick[1]; end
      OWN_A:   a_gnt = a_in.req;
      OWN_B:   b_gnt = b_in.req;
      default: owner_nxt = IDLE;
    endcase
    // Reset kills any grant in the same cycle, so a pending burst access is dropped.
    if (reset) begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
    end
    if (a_gnt)      owner_nxt = a_in.lock ? OWN_A : IDLE;
    else if (b_gnt) owner_nxt = b_in.lock ? OWN_B : IDLE;
  end

  assign port_a.gnt = a_gnt;
  assign port_b.gnt = b_gnt;

  // Only one port is ever granted, so a single shared access path serves both.
  assign sel           = b_gnt ? b_in : a_in;
  assign sel_valid     = a_gnt | b_gnt;
  assign sel_in_range  = {1'b0, sel.addr} < REG_LIMIT;
  assign sel_protected = b_gnt & WP_MASK[sel.addr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner       <= IDLE;
      last_winner <= WINNER_B;
    end else begin
      owner <= owner_nxt;
      if (a_gnt)      last_winner <= WINNER_A;
      else if (b_gnt) last_winner <= WINNER_B;
    end
  end

  // NOTE: the bank is explicitly cleared on reset because IO sees it directly; it maps to flops, not RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REGCOUNT; i++) regs[i] <= 8'h00;
    end else if (sel_valid && sel.we && sel_in_range && !sel_protected) begin
      regs[sel.addr] <= sel.wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      port_a.rvalid <= 1'b0;
      port_a.rdata  <= 8'h00;
      port_b.rvalid <= 1'b0;
      port_b.rdata  <= 8'h00;
      b_wp_err      <= 1'b0;
      conflict_cnt  <= 8'h00;
    end else begin
      port_a.rvalid <= a_gnt & ~a_in.we;
      port_b.rvalid <= b_gnt & ~b_in.we;
      if (a_gnt && !a_in.we) port_a.rdata <= sel_in_range ? regs[sel.addr] : 8'h00;
      if (b_gnt && !b_in.we) port_b.rdata <= sel_in_range ? regs[sel.addr] : 8'h00;
      b_wp_err <= b_gnt & b_in.we & (~sel_in_range | WP_MASK[sel.addr]);
      if (a_in.req && b_in.req && conflict_cnt != 8'hFF) conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

  always_comb begin
    registers_packed = '0;
    for (int i = 0; i < REGCOUNT; i++) registers_packed[8*i +: 8] = regs[i];
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter (REGCOUNT=12, WP_MASK=16'h0001, round-robin ties).
module tb_reg_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        b_wp_err;
  logic [7:0]  conflict_cnt;
  logic [95:0] registers_packed;

  int tests = 0;
  int fails = 0;

  reg_bank_arbiter_if pa ();
  reg_bank_arbiter_if pb ();

  reg_bank_arbiter #(
    .REGCOUNT   (12),
    .A_PRIORITY (1'b0),
    .WP_MASK    (16'h0001)
  ) dut (
    .clock            (clk),
    .reset            (reset),
    .port_a           (pa),
    .port_b           (pb),
    .b_wp_err         (b_wp_err),
    .conflict_cnt     (conflict_cnt),
    .registers_packed (registers_packed)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        a_req, a_we, a_lock;
    logic [3:0]  a_addr;
    logic [7:0]  a_wdata;
    logic        b_req, b_we, b_lock;
    logic [3:0]  b_addr;
    logic [7:0]  b_wdata;
    logic        e_agnt, e_bgnt;
    logic        e_arv;
    logic [7:0]  e_ard;
    logic        e_brv;
    logic [7:0]  e_brd;
    logic        e_wp;
    logic [7:0]  e_cnt;
    logic [95:0] e_pk;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ar, aw, al, input logic [3:0] aa, input logic [7:0] ad,
                       input logic br, bw, bl, input logic [3:0] ba, input logic [7:0] bd);
    pa.req = ar; pa.we = aw; pa.lock = al; pa.addr = aa; pa.wdata = ad;
    pb.req = br; pb.we = bw; pb.lock = bl; pb.addr = ba; pb.wdata = bd;
  endtask

  initial begin
    // Expected registered outputs are those visible during the step (set by the previous edge).
    vecs[0]  = '{1'b1,1'b1,1'b0,4'd3,8'h5A, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b0,8'd0, 96'h0};
    vecs[1]  = '{1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,1'b0,4'd3,8'h00, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b0,8'd0, 96'h5A000000};
    vecs[2]  = '{1'b1,1'b0,1'b0,4'd3,8'h00, 1'b1,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0, 1'b0,8'h00, 1'b1,8'h5A, 1'b0,8'd0, 96'h5A000000};
    vecs[3]  = '{1'b1,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b1, 1'b1,8'h5A, 1'b0,8'h5A, 1'b0,8'd1, 96'h5A000000};
    vecs[4]  = '{1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0, 1'b0,8'h5A, 1'b1,8'h00, 1'b0,8'd2, 96'h5A000000};
    vecs[5]  = '{1'b1,1'b1,1'b1,4'd0,8'h11, 1'b1,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0, 1'b0,8'h5A, 1'b0,8'h00, 1'b0,8'd2, 96'h5A000000};
    vecs[6]  = '{1'b1,1'b1,1'b1,4'd1,8'h22, 1'b1,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0, 1'b0,8'h5A, 1'b0,8'h00, 1'b0,8'd3, 96'h5A000011};
    vecs[7]  = '{1'b1,1'b1,1'b0,4'd2,8'h33, 1'b1,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0, 1'b0,8'h5A, 1'b0,8'h00, 1'b0,8'd4, 96'h5A002211};
    vecs[8]  = '{1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b1, 1'b0,8'h5A, 1'b0,8'h00, 1'b0,8'd5, 96'h5A332211};
    vecs[9]  = '{1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0, 1'b0,8'h5A, 1'b1,8'h11, 1'b0,8'd5, 96'h5A332211};
    vecs[10] = '{1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b1,1'b0,4'd0,8'hFF, 1'b0,1'b1, 1'b0,8'h5A, 1'b0,8'h11, 1'b0,8'd5, 96'h5A332211};
    vecs[11] = '{1'b1,1'b1,1'b0,4'd0,8'hFF, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0, 1'b0,8'h5A, 1'b0,8'h11, 1'b1,8'd5, 96'h5A332211};
    vecs[12] = '{1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0, 1'b0,8'h5A, 1'b0,8'h11, 1'b0,8'd5, 96'h5A3322FF};
    vecs[13] = '{1'b1,1'b0,1'b0,4'd13,8'h00, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0, 1'b0,8'h5A, 1'b0,8'h11, 1'b0,8'd5, 96'h5A3322FF};
    vecs[14] = '{1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0, 1'b1,8'h00, 1'b0,8'h11, 1'b0,8'd5, 96'h5A3322FF};
    vecs[15] = '{1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b1,1'b0,4'd14,8'h77, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h11, 1'b0,8'd5, 96'h5A3322FF};
    vecs[16] = '{1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h11, 1'b1,8'd5, 96'h5A3322FF};
    vecs[17] = '{1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b1,1'b0,4'd1,8'h44, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h11, 1'b0,8'd5, 96'h5A3322FF};
    vecs[18] = '{1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h11, 1'b0,8'd5, 96'h5A3344FF};
    vecs[19] = '{1'b1,1'b1,1'b1,4'd4,8'h55, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h11, 1'b0,8'd5, 96'h5A3344FF};
    vecs[20] = '{1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,1'b0,4'd4,8'h00, 1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h11, 1'b0,8'd5, 96'h555A3344FF};
    vecs[21] = '{1'b1,1'b0,1'b0,4'd4,8'h00, 1'b1,1'b0,1'b0,4'd4,8'h00, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h11, 1'b0,8'd5, 96'h555A3344FF};
    vecs[22] = '{1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,1'b0,4'd4,8'h00, 1'b0,1'b1, 1'b1,8'h55, 1'b0,8'h11, 1'b0,8'd6, 96'h555A3344FF};
    vecs[23] = '{1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0, 1'b0,8'h55, 1'b1,8'h55, 1'b0,8'd6, 96'h555A3344FF};

    // Reset with both ports requesting: no grants, no counting, everything cleared.
    reset = 1'b1;
    drive(1'b1,1'b1,1'b1,4'd3,8'hAA, 1'b1,1'b1,1'b1,4'd2,8'hBB);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst a_gnt", pa.gnt, 1'b0);
    check("rst b_gnt", pb.gnt, 1'b0);
    check("rst a_rvalid", pa.rvalid, 1'b0);
    check("rst b_rvalid", pb.rvalid, 1'b0);
    check("rst a_rdata", pa.rdata, 8'h00);
    check("rst b_rdata", pb.rdata, 8'h00);
    check("rst b_wp_err", b_wp_err, 1'b0);
    check("rst conflict_cnt", conflict_cnt, 8'h00);
    check("rst registers", registers_packed, 96'h0);

    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(vecs[i].a_req, vecs[i].a_we, vecs[i].a_lock, vecs[i].a_addr, vecs[i].a_wdata,
            vecs[i].b_req, vecs[i].b_we, vecs[i].b_lock, vecs[i].b_addr, vecs[i].b_wdata);
      @(negedge clk);
      check($sformatf("v%0d a_gnt", i), pa.gnt, vecs[i].e_agnt);
      check($sformatf("v%0d b_gnt", i), pb.gnt, vecs[i].e_bgnt);
      check($sformatf("v%0d a_rvalid", i), pa.rvalid, vecs[i].e_arv);
      check($sformatf("v%0d a_rdata", i), pa.rdata, vecs[i].e_ard);
      check($sformatf("v%0d b_rvalid", i), pb.rvalid, vecs[i].e_brv);
      check($sformatf("v%0d b_rdata", i), pb.rdata, vecs[i].e_brd);
      check($sformatf("v%0d b_wp_err", i), b_wp_err, vecs[i].e_wp);
      check($sformatf("v%0d conflict_cnt", i), conflict_cnt, vecs[i].e_cnt);
      check($sformatf("v%0d registers", i), registers_packed, vecs[i].e_pk);
    end

    // Saturation: 300 cycles of simultaneous requests from a count of 6; never a double grant.
    begin
      logic double_gnt;
      double_gnt = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(posedge clk);
        #1;
        drive(1'b1,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,1'b0,4'd0,8'h00);
        @(negedge clk);
        if (pa.gnt && pb.gnt) double_gnt = 1'b1;
      end
      check("sat no double grant", double_gnt, 1'b0);
    end
    @(posedge clk);
    #1;
    drive(1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd0,8'h00);
    @(negedge clk);
    check("sat conflict_cnt", conflict_cnt, 8'hFF);

    // Reset mid-burst: A takes ownership, then reset arrives with A's next write pending.
    @(posedge clk);
    #1;
    drive(1'b1,1'b1,1'b1,4'd5,8'h99, 1'b0,1'b0,1'b0,4'd0,8'h00);
    @(negedge clk);
    check("burst lock a_gnt", pa.gnt, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1,1'b1,1'b1,4'd6,8'h66, 1'b1,1'b0,1'b0,4'd0,8'h00);
    @(negedge clk);
    check("rst burst a_gnt", pa.gnt, 1'b0);
    check("rst burst b_gnt", pb.gnt, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0,1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,1'b0,4'd0,8'h00);
    @(negedge clk);
    check("post rst b_gnt", pb.gnt, 1'b1);
    check("post rst a_gnt", pa.gnt, 1'b0);
    check("post rst registers", registers_packed, 96'h0);
    check("post rst conflict_cnt", conflict_cnt, 8'h00);
    @(posedge clk);
    #1;
    drive(1'b0,1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd0,8'h00);
    @(negedge clk);
    check("post rst b_rvalid", pb.rvalid, 1'b1);
    check("post rst b_rdata", pb.rdata, 8'h00);
    check("post rst a_rvalid", pa.rvalid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
